// File: rtl/escalonador_rr_param.sv
// Parametrised round-robin process scheduler.
// Keeps MAX_PROC process slots (valid bit, process ID, saved PC), accepts
// add/kill requests and rotates the running process on quantum expiry.
// All state changes on the falling edge of clock; reset is asynchronous.
module escalonador_rr_param #(
    parameter int DATA_W   = 32,
    parameter int MAX_PROC = 8,
    parameter int IDX_W    = 3,
    parameter int QUANTUM  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              add_valid,
    input  logic [DATA_W-1:0] add_pid,
    input  logic [DATA_W-1:0] add_pc,
    output logic              add_ready,
    input  logic              kill_valid,
    input  logic [IDX_W-1:0]  kill_slot,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] processo_atual,
    output logic [IDX_W-1:0]  slot_atual,
    output logic [DATA_W-1:0] pc_processo_atual,
    output logic              troca_contexto,
    output logic [IDX_W:0]    num_ativos,
    output logic              ocioso
);

    localparam int CNT_W = $clog2(QUANTUM) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    counter_r, counter_next_s;
    logic [MAX_PROC-1:0] valid_r, valid_next_s;
    logic [DATA_W-1:0]   pid_r [MAX_PROC];
    logic [DATA_W-1:0]   spc_r [MAX_PROC];

    logic [DATA_W-1:0]   processo_atual_r, pc_processo_atual_r;
    logic [IDX_W-1:0]    slot_atual_r;
    logic                troca_contexto_r;

    logic [IDX_W:0]      num_ativos_s;
    logic                add_ready_s, add_fire_s, kill_fire_s, kill_run_s;
    logic                free_found_s, low_found_s, nxt_found_s;
    logic [IDX_W-1:0]    free_idx_s, low_idx_s, nxt_idx_s;
    logic                sw_s, idle_s, save_s;
    logic [IDX_W-1:0]    sw_idx_s;
    logic [DATA_W-1:0]   sw_pid_s, sw_pc_s;

    // Lowest set bit of v, returned as {found, index}.
    function automatic logic [IDX_W:0] find_lowest(input logic [MAX_PROC-1:0] v);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = MAX_PROC - 1; i >= 0; i--) begin
            if (v[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    // First set bit of v scanning circularly from cur+1; cur itself is checked last.
    function automatic logic [IDX_W:0] find_next(input logic [MAX_PROC-1:0] v,
                                                 input logic [IDX_W-1:0]    cur);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = MAX_PROC; i >= 1; i--) begin
            idx = (int'(cur) + i) % MAX_PROC;
            if (v[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    // Slot bookkeeping: occupancy, handshake qualification and post-update valid bits.
    always_comb begin
        num_ativos_s = '0;
        for (int i = 0; i < MAX_PROC; i++) begin
            num_ativos_s = num_ativos_s + (IDX_W+1)'(valid_r[i]);
        end
        add_ready_s = (num_ativos_s < (IDX_W+1)'(MAX_PROC));
        // Free slot is searched before this edge's kill, so a freed slot is not reused at once.
        {free_found_s, free_idx_s} = find_lowest(~valid_r);
        add_fire_s  = add_valid && add_ready_s && free_found_s;
        kill_fire_s = 1'b0;
        for (int i = 0; i < MAX_PROC; i++) begin
            if (kill_valid && (kill_slot == IDX_W'(i)) && valid_r[i]) begin
                kill_fire_s = 1'b1;
            end else begin
                kill_fire_s = kill_fire_s;
            end
        end
        kill_run_s   = kill_fire_s && (kill_slot == slot_atual_r);
        valid_next_s = valid_r;
        if (add_fire_s) begin
            valid_next_s[free_idx_s] = 1'b1;
        end else begin
            valid_next_s = valid_next_s;
        end
        if (kill_fire_s) begin
            valid_next_s[kill_slot] = 1'b0;
        end else begin
            valid_next_s = valid_next_s;
        end
        {low_found_s, low_idx_s} = find_lowest(valid_next_s);
        {nxt_found_s, nxt_idx_s} = find_next(valid_next_s, slot_atual_r);
    end

    // Scheduler FSM next-state: dispatch from idle, quantum rotation and forced switch on kill.
    always_comb begin
        state_next_s   = state_r;
        counter_next_s = counter_r;
        sw_s           = 1'b0;
        sw_idx_s       = slot_atual_r;
        idle_s         = 1'b0;
        save_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                counter_next_s = '0;
                if (low_found_s) begin
                    state_next_s = ST_RUN;
                    sw_s         = 1'b1;
                    sw_idx_s     = low_idx_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (kill_run_s) begin
                    // Running slot is already cleared in valid_next_s, so any hit is another slot.
                    counter_next_s = '0;
                    if (nxt_found_s) begin
                        sw_s     = 1'b1;
                        sw_idx_s = nxt_idx_s;
                    end else begin
                        state_next_s = ST_IDLE;
                        idle_s       = 1'b1;
                    end
                end else if (enable) begin
                    if (counter_r == CNT_W'(QUANTUM - 1)) begin
                        save_s         = 1'b1;
                        counter_next_s = '0;
                        if (nxt_found_s && (nxt_idx_s != slot_atual_r)) begin
                            sw_s     = 1'b1;
                            sw_idx_s = nxt_idx_s;
                        end else begin
                            sw_s = 1'b0;
                        end
                    end else begin
                        counter_next_s = counter_r + CNT_W'(1);
                    end
                end else begin
                    counter_next_s = counter_r;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                counter_next_s = '0;
            end
        endcase
        // A slot written this edge is not in the table yet; forward the incoming values.
        if (add_fire_s && (free_idx_s == sw_idx_s)) begin
            sw_pid_s = add_pid;
            sw_pc_s  = add_pc;
        end else begin
            sw_pid_s = pid_r[sw_idx_s];
            sw_pc_s  = spc_r[sw_idx_s];
        end
    end

    // Process table: valid bits, IDs and saved PCs.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
            for (int i = 0; i < MAX_PROC; i++) begin
                pid_r[i] <= '0;
                spc_r[i] <= '0;
            end
        end else begin
            valid_r <= valid_next_s;
            for (int i = 0; i < MAX_PROC; i++) begin
                if (add_fire_s && (free_idx_s == IDX_W'(i))) begin
                    pid_r[i] <= add_pid;
                    spc_r[i] <= add_pc;
                end else if (save_s && (slot_atual_r == IDX_W'(i))) begin
                    spc_r[i] <= pc;
                end else begin
                    spc_r[i] <= spc_r[i];
                end
            end
        end
    end

    // FSM state, quantum counter and registered running-process outputs.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_r             <= ST_IDLE;
            counter_r           <= '0;
            processo_atual_r    <= '0;
            slot_atual_r        <= '0;
            pc_processo_atual_r <= '0;
            troca_contexto_r    <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            counter_r        <= counter_next_s;
            troca_contexto_r <= sw_s;
            if (sw_s) begin
                processo_atual_r    <= sw_pid_s;
                slot_atual_r        <= sw_idx_s;
                pc_processo_atual_r <= sw_pc_s;
            end else if (idle_s) begin
                processo_atual_r <= '0;
            end else begin
                processo_atual_r <= processo_atual_r;
            end
        end
    end

    assign processo_atual    = processo_atual_r;
    assign slot_atual        = slot_atual_r;
    assign pc_processo_atual = pc_processo_atual_r;
    assign troca_contexto    = troca_contexto_r;
    assign num_ativos        = num_ativos_s;
    assign add_ready         = add_ready_s;
    assign ocioso            = (num_ativos_s == '0);

endmodule

// File: tb/tb_escalonador_rr_param.sv
// Directed bench for escalonador_rr_param (default parameters).
module tb_escalonador_rr_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        add_valid;
    logic [31:0] add_pid;
    logic [31:0] add_pc;
    logic        add_ready;
    logic        kill_valid;
    logic [2:0]  kill_slot;
    logic [31:0] pc;
    logic [31:0] processo_atual;
    logic [2:0]  slot_atual;
    logic [31:0] pc_processo_atual;
    logic        troca_contexto;
    logic [3:0]  num_ativos;
    logic        ocioso;

    int checks = 0;
    int errors = 0;
    int strobes;

    escalonador_rr_param dut (
        .clock(clock), .reset(reset), .enable(enable),
        .add_valid(add_valid), .add_pid(add_pid), .add_pc(add_pc), .add_ready(add_ready),
        .kill_valid(kill_valid), .kill_slot(kill_slot), .pc(pc),
        .processo_atual(processo_atual), .slot_atual(slot_atual),
        .pc_processo_atual(pc_processo_atual), .troca_contexto(troca_contexto),
        .num_ativos(num_ativos), .ocioso(ocioso)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active (falling) edge and settle.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic run_cycles(input int n, output int s);
        s = 0;
        repeat (n) begin
            step();
            if (troca_contexto === 1'b1) s++;
        end
    endtask

    // One full quantum from a fresh counter: 9 quiet edges, then the switch.
    task automatic quantum(input string tag, input logic [31:0] pid,
                           input logic [31:0] pcv, input logic [2:0] slot);
        int s;
        run_cycles(9, s);
        check({tag, "_quiet"}, 64'(s), 64'd0);
        step();
        check({tag, "_strobe"}, 64'(troca_contexto), 64'd1);
        check({tag, "_pid"}, 64'(processo_atual), 64'(pid));
        check({tag, "_pc"}, 64'(pc_processo_atual), 64'(pcv));
        check({tag, "_slot"}, 64'(slot_atual), 64'(slot));
    endtask

    task automatic add(input logic [31:0] pid, input logic [31:0] pcv);
        add_valid = 1'b1;
        add_pid   = pid;
        add_pc    = pcv;
        step();
        add_valid = 1'b0;
    endtask

    task automatic kill(input logic [2:0] slot);
        kill_valid = 1'b1;
        kill_slot  = slot;
        step();
        kill_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_troca"}, 64'(troca_contexto), 64'd0);
        check({tag, "_pid"}, 64'(processo_atual), 64'd0);
        check({tag, "_slot"}, 64'(slot_atual), 64'd0);
        check({tag, "_pcout"}, 64'(pc_processo_atual), 64'd0);
        check({tag, "_num"}, 64'(num_ativos), 64'd0);
        check({tag, "_ocioso"}, 64'(ocioso), 64'd1);
        check({tag, "_ready"}, 64'(add_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; add_valid = 1'b0; add_pid = 32'd0; add_pc = 32'd0;
        kill_valid = 1'b0; kill_slot = 3'd0; pc = 32'd0;
        #12;
        check_reset_values("rst");
        #10;
        reset = 1'b0;
        step();

        // Dispatch from idle on the first add.
        add(32'h11, 32'h100);
        check("t1_strobe", 64'(troca_contexto), 64'd1);
        check("t1_pid", 64'(processo_atual), 64'h11);
        check("t1_pcout", 64'(pc_processo_atual), 64'h100);
        check("t1_slot", 64'(slot_atual), 64'd0);
        check("t1_ocioso", 64'(ocioso), 64'd0);
        check("t1_num", 64'(num_ativos), 64'd1);

        // Round robin over three processes; saved PC comes back on return.
        add(32'h22, 32'h200);
        check("t2_single_strobe", 64'(troca_contexto), 64'd0);
        add(32'h33, 32'h300);
        check("t2_num", 64'(num_ativos), 64'd3);
        pc = 32'h1AB;
        enable = 1'b1;
        quantum("t2_q1", 32'h22, 32'h200, 3'd1);
        step();
        check("t2_one_cycle", 64'(troca_contexto), 64'd0);
        run_cycles(8, strobes);
        step();
        check("t2_q2_strobe", 64'(troca_contexto), 64'd1);
        check("t2_q2_pid", 64'(processo_atual), 64'h33);
        quantum("t2_q3", 32'h11, 32'h1AB, 3'd0);

        // Kill running slot 0 at counter 4: immediate switch, counter restarts.
        run_cycles(4, strobes);
        check("t4_pre_quiet", 64'(strobes), 64'd0);
        kill(3'd0);
        check("t4_kill_strobe", 64'(troca_contexto), 64'd1);
        check("t4_kill_pid", 64'(processo_atual), 64'h22);
        check("t4_kill_slot", 64'(slot_atual), 64'd1);
        check("t4_kill_pc", 64'(pc_processo_atual), 64'h1AB);
        quantum("t4_after", 32'h33, 32'h1AB, 3'd2);
        enable = 1'b0;
        kill(3'd1);
        check("t4_other_kill_strobe", 64'(troca_contexto), 64'd0);
        check("t4_other_kill_pid", 64'(processo_atual), 64'h33);
        check("t4_other_kill_num", 64'(num_ativos), 64'd1);
        kill(3'd2);
        check("t4_last_ocioso", 64'(ocioso), 64'd1);
        check("t4_last_pid", 64'(processo_atual), 64'd0);
        check("t4_last_strobe", 64'(troca_contexto), 64'd0);
        check("t4_last_num", 64'(num_ativos), 64'd0);
        kill(3'd5);
        check("t4_invalid_kill_num", 64'(num_ativos), 64'd0);

        // Fill the table, overflow, free slot 3 and refill it.
        for (int i = 0; i < 8; i++) begin
            add(32'h40 + 32'(i), 32'h1000 + 32'(i * 16));
        end
        check("t3_full_ready", 64'(add_ready), 64'd0);
        check("t3_full_num", 64'(num_ativos), 64'd8);
        check("t3_full_pid", 64'(processo_atual), 64'h40);
        add(32'h99, 32'h9990);
        check("t3_overflow_num", 64'(num_ativos), 64'd8);
        kill(3'd3);
        check("t3_kill_ready", 64'(add_ready), 64'd1);
        check("t3_kill_num", 64'(num_ativos), 64'd7);
        add(32'h77, 32'h7770);
        check("t3_refill_num", 64'(num_ativos), 64'd8);
        enable = 1'b1;
        quantum("t3_r1", 32'h41, 32'h1010, 3'd1);
        quantum("t3_r2", 32'h42, 32'h1020, 3'd2);
        quantum("t3_r3", 32'h77, 32'h7770, 3'd3);

        // Enable low mid-quantum freezes the counter.
        run_cycles(4, strobes);
        check("t5_pre_quiet", 64'(strobes), 64'd0);
        enable = 1'b0;
        run_cycles(20, strobes);
        check("t5_hold_quiet", 64'(strobes), 64'd0);
        enable = 1'b1;
        run_cycles(5, strobes);
        check("t5_resume_quiet", 64'(strobes), 64'd0);
        step();
        check("t5_resume_strobe", 64'(troca_contexto), 64'd1);
        check("t5_resume_pid", 64'(processo_atual), 64'h44);
        check("t5_resume_pc", 64'(pc_processo_atual), 64'h1040);

        // Single process: expiries are silent; async reset mid-quantum.
        reset = 1'b1;
        #1;
        check_reset_values("t6_rst1");
        step();
        reset = 1'b0;
        step();
        add(32'h55, 32'h500);
        check("t6_dispatch", 64'(troca_contexto), 64'd1);
        run_cycles(25, strobes);
        check("t6_single_quiet", 64'(strobes), 64'd0);
        check("t6_single_pid", 64'(processo_atual), 64'h55);
        check("t6_single_pc", 64'(pc_processo_atual), 64'h500);
        run_cycles(3, strobes);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_rst2");
        step();
        reset = 1'b0;
        run_cycles(3, strobes);
        check("t6_post_quiet", 64'(strobes), 64'd0);
        check("t6_post_ocioso", 64'(ocioso), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/escalonador_rr_param.md
Name: escalonador_rr_param

Overview:
Parametrised round-robin process scheduler for the LabSO processor, successor to the fixed 5-entry scheduler. It keeps a table of up to MAX_PROC process slots, each with valid bit, process ID and saved PC. Processes are added and killed through handshakes. On quantum expiry it saves the running PC, selects the next valid slot in circular order and pulses a context-switch strobe with the PC to restore. It sits between the OS-call decode logic and the PC/fetch stage.

Parameters:
DATA_W, 32, width of process ID and PC fields
MAX_PROC, 8, number of process slots (2..16)
IDX_W, 3, slot index width; must equal clog2(MAX_PROC)
QUANTUM, 10, clock cycles per time slice (>=2)

Ports:
clock  in  1  system clock; all state updates on falling edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  quantum counter advances only when 1 (processor halted -> 0)
add_valid  in  1  request to register a new process
add_pid  in  DATA_W  ID of new process
add_pc  in  DATA_W  start PC of new process
add_ready  out  1  1 when at least one free slot exists
kill_valid  in  1  request to terminate a slot
kill_slot  in  IDX_W  slot to terminate
pc  in  DATA_W  current PC of the running process
processo_atual  out  DATA_W  ID of running process (0 when idle)
slot_atual  out  IDX_W  slot index of running process
pc_processo_atual  out  DATA_W  PC to load on a context switch
troca_contexto  out  1  one-cycle switch strobe
num_ativos  out  IDX_W+1  count of valid slots
ocioso  out  1  1 when no slot is valid

Behaviour:
- Reset (async): all valid bits 0, counter 0, processo_atual 0, slot_atual 0, pc_processo_atual 0, troca_contexto 0, num_ativos 0, ocioso 1, add_ready 1. Reset mid-switch aborts it; no strobe is emitted after reset.
- Add: add_valid && add_ready at a falling edge writes add_pid/add_pc into the lowest-index free slot and sets its valid bit. num_ativos updates the same edge. add_valid while !add_ready is dropped; no table change.
- Kill: kill_valid with a valid kill_slot clears that valid bit. Killing an invalid slot is ignored.
- Free-slot search uses valid bits before this edge's kill. A slot freed this edge is not reused by a simultaneous add.
- States: IDLE (ocioso=1), RUN.
- IDLE -> RUN: on the first edge where any slot is valid after updates, select the lowest valid slot. Drive processo_atual/slot_atual/pc_processo_atual from it, pulse troca_contexto, counter=0. No PC save.
- RUN quantum: counter increments when enable=1. On the edge where counter==QUANTUM-1:
  - store pc into the current slot's saved PC;
  - search circularly from slot_atual+1 for a valid slot (wrap MAX_PROC-1 -> 0);
  - if one is found other than current: switch to it, pc_processo_atual = its saved PC, troca_contexto=1 for exactly one cycle, counter=0;
  - if current is the only valid slot: counter=0, no strobe, outputs unchanged.
- Kill of the running slot: next edge forces a switch regardless of counter. No PC save. Circular search from slot_atual+1; strobe and counter=0. If no valid slots remain: go to IDLE, processo_atual=0, no strobe.
- Kill of the running slot and quantum expiry in the same cycle: the kill rule wins.
- Add during RUN never preempts. The new slot joins rotation when the circular search reaches it.
- troca_contexto is otherwise 0. Counter width is clog2(QUANTUM)+1 and never exceeds QUANTUM-1.
- add_ready = (num_ativos < MAX_PROC), combinational from valid bits. ocioso = (num_ativos == 0).

Test Plan:
1. Reset, add pid 0x11/pc 0x100 -> next edge: troca_contexto=1, processo_atual=0x11, pc_processo_atual=0x100, slot_atual=0, ocioso=0.
2. Add 0x11@0x100, 0x22@0x200, 0x33@0x300; pc=0x1AB; wait 10 enabled cycles -> strobe, processo_atual=0x22, pc_processo_atual=0x200. After 3 quanta back at 0x11 with pc_processo_atual=0x1AB.
3. Fill 8 slots -> add_ready=0, num_ativos=8. Ninth add ignored. Kill slot 3 -> add_ready=1; next add lands in slot 3.
4. Two processes; kill running slot 0 at counter=4 -> next edge strobe to slot 1, counter=0. Kill slot 1 -> ocioso=1, processo_atual=0, no strobe.
5. enable=0 for 20 cycles mid-quantum -> no strobe; counter holds. Resume -> switch after the remaining cycles.
6. Single process running: quantum expiries produce no strobe. Assert reset mid-quantum -> all outputs return to reset values immediately.
